// File: rtl/term_collector.sv
// Serial-to-parallel term packer: gathers up to NUM_TERMS words from a valid/ready
// stream into one packed vector and presents it on a registered valid/ready output.
module term_collector #(
  parameter int WORD_WIDTH = 8,
  parameter int NUM_TERMS  = 9,
  localparam int CNT_W     = $clog2(NUM_TERMS + 1)
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_in_valid,
  output logic                            o_in_ready,
  input  logic [WORD_WIDTH-1:0]           i_in_data,
  input  logic                            i_in_last,
  output logic                            o_out_valid,
  input  logic                            i_out_ready,
  output logic [WORD_WIDTH*NUM_TERMS-1:0] o_terms,
  output logic [CNT_W-1:0]                o_num_terms
);

  localparam int VEC_W = WORD_WIDTH * NUM_TERMS;

  typedef enum logic {ASSEMBLE, HOLD} state_t;

  state_t             state_reg, state_next;
  logic [VEC_W-1:0]   assembly_reg, assembly_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [VEC_W-1:0]   terms_reg, terms_next;
  logic [CNT_W-1:0]   num_reg, num_next;
  logic               valid_reg, valid_next;

  logic [VEC_W-1:0]   merged;
  logic               in_ready;
  logic               in_xfer;
  logic               out_free;
  logic               completing;

  assign in_ready   = !i_reset && (state_reg == ASSEMBLE);
  assign in_xfer    = i_in_valid && in_ready;
  // A frame draining this very cycle frees the slot for the next one.
  assign out_free   = !valid_reg || i_out_ready;
  assign completing = in_xfer && (i_in_last || (count_reg == CNT_W'(NUM_TERMS - 1)));

  // Assembly register with the incoming word dropped into slot `count`.
  generate
    for (genvar gi = 0; gi < NUM_TERMS; gi++) begin : g_slot
      assign merged[gi*WORD_WIDTH +: WORD_WIDTH] =
        (count_reg == CNT_W'(gi)) ? i_in_data : assembly_reg[gi*WORD_WIDTH +: WORD_WIDTH];
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    assembly_next = assembly_reg;
    count_next    = count_reg;
    terms_next    = terms_reg;
    num_next      = num_reg;
    valid_next    = valid_reg;

    if (valid_reg && i_out_ready) begin
      valid_next = 1'b0;
    end

    case (state_reg)
      ASSEMBLE: begin
        if (in_xfer) begin
          if (completing && out_free) begin
            terms_next    = merged;
            num_next      = count_reg + CNT_W'(1);
            valid_next    = 1'b1;
            assembly_next = '0;
            count_next    = '0;
          end else begin
            // A completed frame that cannot leave yet parks in the assembly register.
            assembly_next = merged;
            count_next    = count_reg + CNT_W'(1);
            if (completing) begin
              state_next = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (i_out_ready) begin
          terms_next    = assembly_reg;
          num_next      = count_reg;
          valid_next    = 1'b1;
          assembly_next = '0;
          count_next    = '0;
          state_next    = ASSEMBLE;
        end
      end
      default: state_next = ASSEMBLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg    <= ASSEMBLE;
      assembly_reg <= '0;
      count_reg    <= '0;
      terms_reg    <= '0;
      num_reg      <= '0;
      valid_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      assembly_reg <= assembly_next;
      count_reg    <= count_next;
      terms_reg    <= terms_next;
      num_reg      <= num_next;
      valid_reg    <= valid_next;
    end
  end

  assign o_in_ready  = in_ready;
  assign o_out_valid = valid_reg;
  assign o_terms     = terms_reg;
  assign o_num_terms = num_reg;

endmodule

// File: tb/tb_term_collector.sv
// Directed bench for term_collector: a reference packer pushes expected frames into a
// scoreboard as words are driven; frames captured at the output are compared against it.
module tb_term_collector;

  localparam int W  = 8;
  localparam int N  = 9;
  localparam int CW = 4;
  localparam int TW = W * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] terms;
  logic [CW-1:0] num_terms;

  always #5 clk = ~clk;

  term_collector #(.WORD_WIDTH(W), .NUM_TERMS(N)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .i_in_last   (in_last),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_terms     (terms),
    .o_num_terms (num_terms)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Scoreboard of expected frames, filled by the reference packer in send().
  logic [TW-1:0] exp_terms_q[$];
  int            exp_num_q[$];
  logic [TW-1:0] mdl_terms;
  int            mdl_cnt;

  // Frames observed at the output, written only by the monitor.
  logic [TW-1:0] obs_terms[64];
  int            obs_num[64];
  int            obs_cyc[64];
  int            obs_wr    = 0;
  int            obs_rd    = 0;
  int            stall_cnt = 0;
  int            cyc       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && obs_wr < 64) begin
      obs_terms[obs_wr] = terms;
      obs_num[obs_wr]   = int'(num_terms);
      obs_cyc[obs_wr]   = cyc;
      $display("frame %0d: terms=%h num=%0d cycle=%0d", obs_wr, terms, num_terms, cyc);
      obs_wr++;
    end
    if (!rst && in_valid && !in_ready) stall_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int sum_terms(input logic [TW-1:0] t);
    int s = 0;
    for (int k = 0; k < N; k++) s += int'(t[k*W +: W]);
    return s;
  endfunction

  task automatic model_clear();
    mdl_terms = '0;
    mdl_cnt   = 0;
    exp_terms_q.delete();
    exp_num_q.delete();
    obs_rd = obs_wr;
  endtask

  // Drive one word, waiting a bounded time for o_in_ready; returns at posedge+1.
  task automatic send(input logic [W-1:0] d, input logic l);
    int waits = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 50) begin
      check("in_ready_timeout", in_ready, 1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    mdl_terms[mdl_cnt*W +: W] = d;
    mdl_cnt++;
    if (l || mdl_cnt == N) begin
      exp_terms_q.push_back(mdl_terms);
      exp_num_q.push_back(mdl_cnt);
      mdl_terms = '0;
      mdl_cnt   = 0;
    end
  endtask

  // Compare every captured frame against the scoreboard; base = index of first frame.
  task automatic drain(input string tag, output int base);
    logic [TW-1:0] et;
    int en;
    base = obs_rd;
    check({tag, "_frame_count"}, obs_wr - obs_rd, exp_terms_q.size());
    for (int k = obs_rd; k < obs_wr; k++) begin
      if (exp_terms_q.size() > 0) begin
        et = exp_terms_q.pop_front();
        en = exp_num_q.pop_front();
        check({tag, "_terms"}, obs_terms[k], et);
        check({tag, "_num_terms"}, obs_num[k], en);
      end
    end
    obs_rd = obs_wr;
    exp_terms_q.delete();
    exp_num_q.delete();
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int s0;
    logic [TW-1:0] v1, v2;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    model_clear();

    // Reset state
    @(negedge clk);
    check("ready_during_reset", in_ready, 0);
    @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_terms", terms, 0);
    check("reset_num_terms", num_terms, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1);
    @(posedge clk);
    #1;

    // 1: full frame, no last
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) send(W'(i), 1'b0);
    settle();
    drain("full", base);
    check("full_sum", sum_terms(obs_terms[base]), 36);

    // 2: short frame, last on 4th word
    for (int i = 1; i <= 4; i++) send(W'(i), i == 4);
    settle();
    drain("short", base);
    check("short_sum", sum_terms(obs_terms[base]), 10);

    // 3: back-to-back, 27 words
    s0 = stall_cnt;
    for (int i = 0; i < 27; i++) send(W'(i), 1'b0);
    settle();
    check("b2b_stalls", stall_cnt - s0, 0);
    drain("b2b", base);
    check("b2b_sum0", sum_terms(obs_terms[base]), 36);
    check("b2b_sum1", sum_terms(obs_terms[base+1]), 117);
    check("b2b_sum2", sum_terms(obs_terms[base+2]), 198);
    check("b2b_gap01", obs_cyc[base+1] - obs_cyc[base], 9);
    check("b2b_gap12", obs_cyc[base+2] - obs_cyc[base+1], 9);

    // 4: backpressure, 18 words with downstream stalled
    out_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      v1[k*W +: W] = W'(100 + k);
      v2[k*W +: W] = W'(109 + k);
    end
    for (int i = 0; i < 2 * N; i++) send(W'(100 + i), 1'b0);
    @(negedge clk);
    check("bp_hold_in_ready", in_ready, 0);
    check("bp_hold_valid", out_valid, 1);
    check("bp_frame1_stable", terms, v1);
    check("bp_frame1_num", num_terms, 9);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_valid", out_valid, 1);
    check("bp_frame2_terms", terms, v2);
    settle();
    drain("bp", base);

    // 5: reset mid-frame
    for (int i = 0; i < 5; i++) send(W'(50 + i), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    for (int i = 10; i <= 18; i++) send(W'(i), 1'b0);
    settle();
    drain("mid_reset", base);

    // 6: reset while holding a second frame
    out_ready = 1'b0;
    for (int i = 0; i < 2 * N; i++) send(W'(30 + i), 1'b0);
    @(negedge clk);
    check("hold_valid_before_reset", out_valid, 1);
    check("hold_in_ready_before_reset", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    check("hold_reset_valid", out_valid, 0);
    check("hold_reset_terms", terms, 0);
    check("hold_reset_num", num_terms, 0);
    check("hold_reset_in_ready", in_ready, 1);
    out_ready = 1'b1;
    settle();
    drain("hold_reset", base);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
